// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and width limits.
package serial_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half subtractors.
// Latency: combinational. Backpressure: none.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
    half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock LSB first through a single cell.
// Latency: WIDTH cycles from accepted start to a one-cycle done pulse.
// Backpressure: start is ignored while busy; accepted again in the done cycle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of range");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bo;

    full_subtractor u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        diff  <= '0;
                        bout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff <= {d, diff[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= bo;
                    cnt  <= cnt + 1'b1;
                    // The last processed bit is the result MSB, so d is its sign.
                    if (cnt == LAST) begin
                        bout  <= bo;
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Counts negedges from the first cycle after acceptance until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < W + 4) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
        check({tag, "_diff"}, 64'(diff), 64'(ed));
        check({tag, "_bout"}, 64'(bout), 64'(eb));
        check({tag, "_ovf"},  64'(ovf),  64'(eo));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check_result(tag, ed, eb, eo);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_hold"}, 64'(diff), 64'(ed));
    endtask

    initial begin
        int lat;
        int seen;
        logic [8:0] ref9;
        logic [7:0] ra, rb, ed;
        logic       rbin, eo;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
        check("rst_ovf",  64'(ovf),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_5_3");
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_neg");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_pos");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "zero_bin");
        run_op(8'h20, 8'h10, 1'b1, 8'h0F, 1'b0, 1'b0, "bin_mid");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff_ff_bin");

        // start held high and operands churning during RUN must not disturb the result
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        lat = -1;
        while (!done && lat < W + 4) begin
            @(negedge clk);
            lat++;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (lat >= W - 2) start = 1'b0;
        end
        check("held_start_latency", 64'(lat), 64'(W));
        check_result("held_start", 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check("held_start_no_rerun", 64'(busy), 64'(0));

        // start in the done cycle launches the next operation with no idle gap
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b_first_latency", 64'(lat), 64'(W));
        check_result("b2b_first", 8'h0F, 1'b0, 1'b0);
        a = 8'h01; b = 8'h02; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap_busy", 64'(busy), 64'(1));
        wait_done(lat);
        check("b2b_second_latency", 64'(lat), 64'(W));
        check_result("b2b_second", 8'hFF, 1'b1, 1'b0);

        // reset during RUN aborts with no done pulse
        @(negedge clk);
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_diff", 64'(diff), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_bout", 64'(bout), 64'(0));
        check("midrst_ovf",  64'(ovf),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'(0));
        run_op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            ed = ref9[7:0];
            eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
            run_op(ra, rb, rbin, ed, ref9[8], eo, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
